// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter in front of a single-port
// word RAM with registered read data. Each access passes through
// IDLE -> ISSUE -> (WAIT) -> RESP. Misaligned requests skip the RAM and
// complete with an error flag. Every output comes straight from a flop.
module ram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              resetn,

    // requester A
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,

    // requester B
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,

    // RAM side
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_isRead,
    output logic [3:0]        ram_isWrite,
    output logic [DATA_W-1:0] ram_writeData,
    input  logic [DATA_W-1:0] ram_data,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic                r_win_b;       // current winner: 1 = B, 0 = A
    logic                r_last_b;      // 1 = B was granted last, so A wins a tie
    logic                r_we;          // winner's access is a write
    logic                r_mis;         // winner's access is misaligned
    logic [ADDR_W-1:0]   r_ram_address;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic                r_ram_is_read;
    logic [3:0]          r_ram_is_write;
    logic                r_a_ack;
    logic                r_b_ack;
    logic                r_a_err;
    logic                r_b_err;
    logic [DATA_W-1:0]   r_a_rdata;
    logic [DATA_W-1:0]   r_b_rdata;
    logic                r_busy;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t              w_state_next;
    logic                w_win_b_next;
    logic                w_last_b_next;
    logic                w_we_next;
    logic                w_mis_next;
    logic [ADDR_W-1:0]   w_ram_address_next;
    logic [DATA_W-1:0]   w_ram_wdata_next;
    logic                w_ram_is_read_next;
    logic [3:0]          w_ram_is_write_next;
    logic                w_a_ack_next;
    logic                w_b_ack_next;
    logic                w_a_err_next;
    logic                w_b_err_next;
    logic [DATA_W-1:0]   w_a_rdata_next;
    logic [DATA_W-1:0]   w_b_rdata_next;
    logic                w_busy_next;

    // ------------------------------------------------------------------
    // Request qualification and round-robin selection
    // ------------------------------------------------------------------
    // A requester still holds req during its own ack cycle; that stale
    // request must not be granted again. It counts from the next cycle on.
    logic                w_a_live;
    logic                w_b_live;
    logic                w_any_req;
    logic                w_grant_b;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_misaligned;

    assign w_a_live     = a_req & ~r_a_ack;
    assign w_b_live     = b_req & ~r_b_ack;
    assign w_any_req    = w_a_live | w_b_live;
    // B wins when it is alone, or on a tie when A was granted last.
    assign w_grant_b    = w_b_live & (~w_a_live | ~r_last_b);
    assign w_sel_we     = w_grant_b ? b_we    : a_we;
    assign w_sel_addr   = w_grant_b ? b_addr  : a_addr;
    assign w_sel_wdata  = w_grant_b ? b_wdata : a_wdata;
    assign w_misaligned = (w_sel_addr[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // FSM next-state decode
    // ------------------------------------------------------------------
    // Next state of the access sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_next = w_misaligned ? ST_RESP : ST_ISSUE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // writes complete when issued; reads wait for RAM data
                w_state_next = r_we ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output next values
    // ------------------------------------------------------------------
    // Next values of grant bookkeeping, RAM strobes, acks, errors, rdata.
    always_comb begin
        w_win_b_next        = r_win_b;
        w_last_b_next       = r_last_b;
        w_we_next           = r_we;
        w_mis_next          = r_mis;
        w_ram_address_next  = r_ram_address;
        w_ram_wdata_next    = r_ram_wdata;
        w_ram_is_read_next  = 1'b0;
        w_ram_is_write_next = 4'b0000;
        w_a_ack_next        = 1'b0;
        w_b_ack_next        = 1'b0;
        w_a_err_next        = 1'b0;
        w_b_err_next        = 1'b0;
        w_a_rdata_next      = r_a_rdata;
        w_b_rdata_next      = r_b_rdata;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    // every grant moves the pointer, misaligned ones too
                    w_win_b_next  = w_grant_b;
                    w_last_b_next = w_grant_b;
                    w_we_next     = w_sel_we;
                    w_mis_next    = w_misaligned;
                    if (!w_misaligned) begin
                        w_ram_address_next = w_sel_addr;
                        w_ram_wdata_next   = w_sel_wdata;
                        if (w_sel_we) begin
                            w_ram_is_write_next = 4'b1111;
                        end else begin
                            w_ram_is_read_next  = 1'b1;
                        end
                    end else begin
                        // no RAM access for a misaligned request
                        w_ram_address_next = r_ram_address;
                    end
                end else begin
                    w_win_b_next = r_win_b;
                end
            end
            ST_ISSUE: begin
                // strobes fall back to idle through the defaults
                w_mis_next = r_mis;
            end
            ST_WAIT: begin
                // RAM data issued last cycle is valid now
                if (r_win_b) begin
                    w_b_rdata_next = ram_data;
                end else begin
                    w_a_rdata_next = ram_data;
                end
            end
            ST_RESP: begin
                if (r_win_b) begin
                    w_b_ack_next = 1'b1;
                    w_b_err_next = r_mis;
                end else begin
                    w_a_ack_next = 1'b1;
                    w_a_err_next = r_mis;
                end
            end
            default: begin
                w_mis_next = r_mis;
            end
        endcase
    end

    // busy is a registered copy of "not heading to IDLE"
    assign w_busy_next = (w_state_next != ST_IDLE);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // Register all state and outputs; reset clears every output at once.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_win_b        <= 1'b0;
            r_last_b       <= 1'b1;          // A has priority after reset
            r_we           <= 1'b0;
            r_mis          <= 1'b0;
            r_ram_address  <= {ADDR_W{1'b0}};
            r_ram_wdata    <= {DATA_W{1'b0}};
            r_ram_is_read  <= 1'b0;
            r_ram_is_write <= 4'b0000;
            r_a_ack        <= 1'b0;
            r_b_ack        <= 1'b0;
            r_a_err        <= 1'b0;
            r_b_err        <= 1'b0;
            r_a_rdata      <= {DATA_W{1'b0}};
            r_b_rdata      <= {DATA_W{1'b0}};
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_win_b        <= w_win_b_next;
            r_last_b       <= w_last_b_next;
            r_we           <= w_we_next;
            r_mis          <= w_mis_next;
            r_ram_address  <= w_ram_address_next;
            r_ram_wdata    <= w_ram_wdata_next;
            r_ram_is_read  <= w_ram_is_read_next;
            r_ram_is_write <= w_ram_is_write_next;
            r_a_ack        <= w_a_ack_next;
            r_b_ack        <= w_b_ack_next;
            r_a_err        <= w_a_err_next;
            r_b_err        <= w_b_err_next;
            r_a_rdata      <= w_a_rdata_next;
            r_b_rdata      <= w_b_rdata_next;
            r_busy         <= w_busy_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign a_ack         = r_a_ack;
    assign a_rdata       = r_a_rdata;
    assign a_err         = r_a_err;
    assign b_ack         = r_b_ack;
    assign b_rdata       = r_b_rdata;
    assign b_err         = r_b_err;
    assign ram_address   = r_ram_address;
    assign ram_isRead    = r_ram_is_read;
    assign ram_isWrite   = r_ram_is_write;
    assign ram_writeData = r_ram_wdata;
    assign busy          = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural
// word RAM (registered read data, write on 4'b1111).
module tb_ram_arbiter;

    logic        clock;
    logic        resetn;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [15:0] ram_address;
    logic        ram_isRead;
    logic [3:0]  ram_isWrite;
    logic [31:0] ram_writeData;
    bit   [31:0] ram_data;
    logic        busy;

    bit   [31:0] mem [0:16383];

    int n_pass  = 0;
    int n_total = 0;

    ram_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clock(clock), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .ram_address(ram_address), .ram_isRead(ram_isRead),
        .ram_isWrite(ram_isWrite), .ram_writeData(ram_writeData),
        .ram_data(ram_data), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // behavioural RAM: write on full strobe, registered read
    always @(posedge clock) begin
        if (ram_isWrite == 4'b1111) mem[ram_address[15:2]] <= ram_writeData;
        if (ram_isRead) ram_data <= mem[ram_address[15:2]];
    end

    // one access on one port; lat counts edges after the sampling edge T
    task automatic do_access(input logic port_b, input logic we,
                             input logic [15:0] addr, input logic [31:0] wdata,
                             output int lat, output logic [31:0] rdata,
                             output logic err, output logic saw_ram,
                             output logic saw_both, output logic [15:0] issue_addr);
        @(posedge clock); #1;
        if (port_b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        lat = -1; rdata = 32'h0; err = 1'b0;
        saw_ram = 1'b0; saw_both = 1'b0; issue_addr = 16'h0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (ram_isRead || ram_isWrite != 4'b0000) begin
                saw_ram = 1'b1;
                issue_addr = ram_address;
            end
            if (ram_isRead && ram_isWrite != 4'b0000) saw_both = 1'b1;
            if (port_b ? b_ack : a_ack) begin
                lat   = n;
                rdata = port_b ? b_rdata : a_rdata;
                err   = port_b ? b_err : a_err;
                break;
            end
        end
        if (port_b) b_req = 1'b0; else a_req = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = 16'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 16'h0; b_wdata = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_total++;
        if ({a_ack, a_err, b_ack, b_err, busy, ram_isRead} !== 6'b000000) begin
            $display("FAIL reset_flags got %b want 000000",
                     {a_ack, a_err, b_ack, b_err, busy, ram_isRead});
        end else n_pass++;
        n_total++;
        if (ram_isWrite !== 4'b0000) $display("FAIL reset_iswrite got %h want 0", ram_isWrite);
        else n_pass++;
        n_total++;
        if ({a_rdata, b_rdata, ram_writeData, ram_address} !== 112'h0) begin
            $display("FAIL reset_data got %h %h %h %h want 0", a_rdata, b_rdata,
                     ram_writeData, ram_address);
        end else n_pass++;
        resetn = 1'b1;
    endtask

    task automatic test_write_read;
        int lat; logic [31:0] rd; logic err, sr, sb; logic [15:0] ia;
        do_access(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, lat, rd, err, sr, sb, ia);
        n_total++;
        if (lat !== 2) $display("FAIL wr_latency got %0d want 2", lat); else n_pass++;
        n_total++;
        if (err !== 1'b0 || sb !== 1'b0) $display("FAIL wr_err_both got %b%b want 00", err, sb);
        else n_pass++;
        do_access(1'b0, 1'b0, 16'h0010, 32'h0, lat, rd, err, sr, sb, ia);
        n_total++;
        if (lat !== 3) $display("FAIL rd_latency got %0d want 3", lat); else n_pass++;
        n_total++;
        if (rd !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", rd); else n_pass++;
        n_total++;
        if (err !== 1'b0 || sb !== 1'b0) $display("FAIL rd_err_both got %b%b want 00", err, sb);
        else n_pass++;
    endtask

    task automatic test_top_word;
        int lat; logic [31:0] rd; logic err, sr, sb; logic [15:0] ia;
        do_access(1'b0, 1'b1, 16'hFFFC, 32'h0000AAAA, lat, rd, err, sr, sb, ia);
        n_total++;
        if (ia !== 16'hFFFC || lat !== 2) $display("FAIL top_wr got addr %h lat %0d want fffc 2", ia, lat);
        else n_pass++;
        do_access(1'b0, 1'b0, 16'hFFFC, 32'h0, lat, rd, err, sr, sb, ia);
        n_total++;
        if (ia !== 16'hFFFC) $display("FAIL top_rd_addr got %h want fffc", ia); else n_pass++;
        n_total++;
        if (rd !== 32'h0000AAAA) $display("FAIL top_rd_data got %h want 0000aaaa", rd); else n_pass++;
    endtask

    task automatic test_round_robin;
        logic [31:0] exp_b_hold;
        @(negedge clock); resetn = 1'b0;
        @(negedge clock); resetn = 1'b1;
        exp_b_hold = 32'h0;
        for (int r = 0; r < 2; r++) begin
            int acks; logic first_b; logic second_b;
            acks = 0; first_b = 1'b1; second_b = 1'b0;
            @(posedge clock); #1;
            a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
            b_req = 1'b1; b_we = 1'b0; b_addr = 16'hFFFC;
            for (int n = 0; n < 40 && acks < 2; n++) begin
                @(negedge clock);
                if (a_ack) begin
                    n_total++;
                    if (b_rdata !== exp_b_hold) $display("FAIL rr_loser_rdata got %h want %h", b_rdata, exp_b_hold);
                    else n_pass++;
                    n_total++;
                    if (a_rdata !== 32'hDEADBEEF) $display("FAIL rr_a_rdata got %h want deadbeef", a_rdata);
                    else n_pass++;
                    if (acks == 0) first_b = 1'b0; else second_b = 1'b0;
                    a_req = 1'b0; acks++;
                end else if (b_ack) begin
                    if (acks == 0) first_b = 1'b1; else second_b = 1'b1;
                    b_req = 1'b0; acks++;
                end
            end
            a_req = 1'b0; b_req = 1'b0;
            n_total++;
            if (acks !== 2 || first_b !== 1'b0 || second_b !== 1'b1)
                $display("FAIL rr_order round %0d got acks %0d first_b %b second_b %b want 2 0 1",
                         r, acks, first_b, second_b);
            else n_pass++;
            exp_b_hold = 32'h0000AAAA;
        end
    endtask

    task automatic test_misaligned;
        int lat; logic [31:0] rd; logic err, sr, sb; logic [15:0] ia;
        do_access(1'b1, 1'b0, 16'h0006, 32'h0, lat, rd, err, sr, sb, ia);
        n_total++;
        if (lat !== 1) $display("FAIL mis_latency got %0d want 1", lat); else n_pass++;
        n_total++;
        if (err !== 1'b1) $display("FAIL mis_err got %b want 1", err); else n_pass++;
        n_total++;
        if (sr !== 1'b0) $display("FAIL mis_ram_access got %b want 0", sr); else n_pass++;
        @(negedge clock);
        n_total++;
        if (b_err !== 1'b0 || b_ack !== 1'b0) $display("FAIL mis_err_after got %b%b want 00", b_err, b_ack);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int acks; int idle; logic [3:0] order;
        acks = 0; idle = 0; order = 4'b0000;
        @(posedge clock); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'hFFFC;
        for (int n = 0; n < 100 && acks < 4; n++) begin
            @(negedge clock);
            if (!busy) idle++;
            if (a_ack || b_ack) begin
                if (acks > 0) begin
                    n_total++;
                    if (idle !== 1) $display("FAIL b2b_idle_gap got %0d want 1", idle); else n_pass++;
                end
                order[acks] = b_ack;
                idle = 0;
                acks++;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        n_total++;
        if (acks !== 4 || order !== 4'b1010) $display("FAIL b2b_order got %0d %b want 4 1010", acks, order);
        else n_pass++;
        n_total++;
        if (a_rdata !== 32'hDEADBEEF || b_rdata !== 32'h0000AAAA)
            $display("FAIL b2b_rdata got %h %h want deadbeef 0000aaaa", a_rdata, b_rdata);
        else n_pass++;
    endtask

    task automatic test_reset_during_issue;
        int lat; logic [31:0] rd; logic err, sr, sb; logic [15:0] ia;
        @(posedge clock); #1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0020; a_wdata = 32'h12345678;
        @(posedge clock); #1;
        n_total++;
        if (ram_isWrite !== 4'b1111 || ram_address !== 16'h0020)
            $display("FAIL rst_issue_pre got %h %h want f 0020", ram_isWrite, ram_address);
        else n_pass++;
        #1 resetn = 1'b0;
        #1;
        n_total++;
        if ({ram_isWrite, ram_isRead, busy, a_ack, a_err, b_ack, b_err} !== 11'h0)
            $display("FAIL rst_issue_flags got %h want 0",
                     {ram_isWrite, ram_isRead, busy, a_ack, a_err, b_ack, b_err});
        else n_pass++;
        n_total++;
        if ({a_rdata, b_rdata, ram_writeData, ram_address} !== 112'h0)
            $display("FAIL rst_issue_data got %h %h %h %h want 0", a_rdata, b_rdata,
                     ram_writeData, ram_address);
        else n_pass++;
        a_req = 1'b0;
        @(negedge clock); resetn = 1'b1;
        do_access(1'b0, 1'b0, 16'h0020, 32'h0, lat, rd, err, sr, sb, ia);
        n_total++;
        if (lat !== 3 || rd === 32'h12345678 || rd !== 32'h0)
            $display("FAIL rst_issue_readback got %h lat %0d want 00000000 3", rd, lat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_top_word();
        test_round_robin();
        test_misaligned();
        test_back_to_back();
        test_reset_during_issue();
        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
